// File: rtl/tetris_pkg.sv
// Shared tetromino types and constants for the piece pipeline.
package tetris_pkg;

   localparam int unsigned piece_width_gp = 3;
   localparam logic [2:0]  piece_invalid_gp = 3'd7;

   typedef enum logic [2:0] {
      I = 3'd0,
      O = 3'd1,
      T = 3'd2,
      S = 3'd3,
      Z = 3'd4,
      J = 3'd5,
      L = 3'd6
   } piece_e;

endpackage

// File: rtl/piece_shift_queue.sv
// Shift queue of piece IDs: entry 0 is the head, dequeue shifts toward the head,
// append lands at the tail. Slots at or above count are kept at zero.
module piece_shift_queue
   import tetris_pkg::*;
#(
   parameter int unsigned els_p = 4
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic                                      enq_i,
   input  logic                                      deq_i,
   input  logic [piece_width_gp-1:0]                 data_i,
   output logic [els_p-1:0][piece_width_gp-1:0]      entries_o,
   output logic [$clog2(els_p+1)-1:0]                count_o,
   output logic                                      valid_o
);

   localparam int unsigned cnt_w = $clog2(els_p + 1);

   logic [els_p-1:0][piece_width_gp-1:0] entries_n;
   logic [cnt_w-1:0]                     count_n;
   logic [cnt_w-1:0]                     tail_idx;

   // Next-state: shift on dequeue, then write the tail slot on enqueue.
   always_comb begin
      entries_n = entries_o;
      count_n   = count_o;
      tail_idx  = deq_i ? (count_o - cnt_w'(1)) : count_o;
      if (deq_i) begin
         for (int unsigned k = 0; k < els_p - 1; k++) begin
            entries_n[k] = entries_o[k+1];
         end
         entries_n[els_p-1] = '0;
      end
      if (enq_i) begin
         for (int unsigned k = 0; k < els_p; k++) begin
            if (cnt_w'(k) == tail_idx) begin
               entries_n[k] = data_i;
            end
         end
      end
      if (enq_i && !deq_i) begin
         count_n = count_o + cnt_w'(1);
      end else if (deq_i && !enq_i) begin
         count_n = count_o - cnt_w'(1);
      end
   end

   // Storage, count and registered valid flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         entries_o <= '0;
         count_o   <= '0;
         valid_o   <= 1'b0;
      end else begin
         entries_o <= entries_n;
         count_o   <= count_n;
         valid_o   <= (count_n != '0);
      end
   end

endmodule

// File: rtl/piece_queue.sv
// Piece queue: filters LFSR words into tetromino IDs and buffers upcoming pieces.
// Optional 7-bag mode is enabled by defining PIECE_QUEUE_BAG_EN.
module piece_queue
   import tetris_pkg::*;
#(
   parameter int unsigned width_p = 4,
   parameter int unsigned els_p   = 4
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [width_p-1:0]                  random_i,
   output logic [piece_width_gp-1:0]           piece_o,
   output logic                                v_o,
   input  logic                                yumi_i,
   output logic [piece_width_gp*els_p-1:0]     preview_o,
   output logic [$clog2(els_p+1)-1:0]          count_o
);

   localparam int unsigned cnt_w = $clog2(els_p + 1);

   logic [piece_width_gp-1:0]                cand;
   logic [els_p-1:0][piece_width_gp-1:0]     entries;
   logic                                     deq;
   logic                                     room;
   logic                                     bag_ok;
   logic                                     accept;
   logic [6:0]                               cand_bit;

   assign cand     = random_i[piece_width_gp-1:0];
   assign cand_bit = 7'(7'd1 << cand);
   assign deq      = yumi_i && v_o;
   assign room     = (count_o < cnt_w'(els_p)) || deq;
   assign accept   = (cand != piece_invalid_gp) && room && bag_ok;

   // Upper LFSR bits carry no information for piece selection.
   generate
      if (width_p > piece_width_gp) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^random_i[width_p-1:piece_width_gp];
      end
   endgenerate

`ifdef PIECE_QUEUE_BAG_EN
   logic [6:0] used_mask;
   logic [6:0] used_next;

   assign bag_ok    = ((used_mask & cand_bit) == 7'd0);
   assign used_next = used_mask | cand_bit;

   // Bag mask: mark each accepted ID, restart the bag once all seven are taken.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         used_mask <= 7'd0;
      end else if (accept) begin
         used_mask <= (used_next == 7'h7f) ? 7'd0 : used_next;
      end
   end
`else
   logic unused_bit;
   assign bag_ok     = 1'b1;
   assign unused_bit = ^cand_bit;
`endif

   piece_shift_queue #(.els_p(els_p)) u_queue (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .enq_i     (accept),
      .deq_i     (deq),
      .data_i    (cand),
      .entries_o (entries),
      .count_o   (count_o),
      .valid_o   (v_o)
   );

   assign piece_o   = entries[0];
   assign preview_o = entries;

`ifndef SYNTHESIS
   // Taking a piece from an empty queue is a consumer protocol error.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(yumi_i && !v_o))
            else $warning("piece_queue: yumi_i asserted while queue empty, ignored");
      end
   end
`endif

endmodule
